// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: drives the shared 24-bit ALU and the dual-read operand
// RAM to form the Q16.8 dot product of two vectors. Each element pair takes
// five cycles: FETCH, LOAD, MUL, SCALE (shift right by 8) and ACCUM. Every
// output comes from a register or is decoded from the registered state, so
// there is no combinational path from alu_c to any output.
module dot_product_sequencer #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  input  logic [DATA_W-1:0] mem_data_a,
  input  logic [DATA_W-1:0] mem_data_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_z,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              result_zero
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_SCALE = 3'd4;
  localparam logic [2:0] S_ACCUM = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_SFTR = 3'd3;

  logic [2:0]        state;
  logic [LEN_W-1:0]  len_r;
  logic [ADDR_W-1:0] base_a_r;
  logic [ADDR_W-1:0] base_b_r;
  // The index only counts up to len-1, so it never wraps before the compare,
  // even for the largest len.
  logic [LEN_W-1:0]  idx;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] sc;
  logic [DATA_W-1:0] acc;
  logic              zflag;

  logic              last_elem;
  assign last_elem = (idx == len_r - LEN_W'(1));

  // State machine and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_r       <= '0;
      base_a_r    <= '0;
      base_b_r    <= '0;
      idx         <= '0;
      ra          <= '0;
      rb          <= '0;
      prod        <= '0;
      sc          <= '0;
      acc         <= '0;
      zflag       <= 1'b0;
      result      <= '0;
      result_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the values from before this edge regardless of statement order.
      case (state)
        S_IDLE: begin
          if (start) begin
            len_r    <= len;
            base_a_r <= base_a;
            base_b_r <= base_b;
            idx      <= '0;
            acc      <= '0;
            // An empty vector yields a zero result, so the flag starts set.
            zflag    <= 1'b1;
            state    <= (len == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          ra    <= mem_data_a;
          rb    <= mem_data_b;
          state <= S_MUL;
        end
        S_MUL: begin
          // Only the low DATA_W bits of the product survive.
          prod  <= alu_c;
          state <= S_SCALE;
        end
        S_SCALE: begin
          sc    <= alu_c;
          state <= S_ACCUM;
        end
        S_ACCUM: begin
          acc   <= alu_c;
          zflag <= alu_z;
          if (last_elem) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + LEN_W'(1);
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          result      <= acc;
          result_zero <= zflag;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state and datapath registers.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    mem_rd_en  = 1'b0;
    mem_addr_a = '0;
    mem_addr_b = '0;
    alu_op     = OP_ADD;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      S_FETCH: begin
        mem_rd_en  = 1'b1;
        mem_addr_a = base_a_r + ADDR_W'(idx);
        mem_addr_b = base_b_r + ADDR_W'(idx);
      end
      S_MUL: begin
        alu_op = OP_MUL;
        alu_a  = ra;
        alu_b  = rb;
      end
      S_SCALE: begin
        alu_op = OP_SFTR;
        alu_a  = prod;
      end
      S_ACCUM: begin
        alu_op = OP_ADD;
        alu_a  = acc;
        alu_b  = sc;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a registered-read operand RAM
// and a combinational ALU around it. Expected values are hand-computed.
module tb_dot_product_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [7:0]  base_a;
  logic [7:0]  base_b;
  logic        mem_rd_en;
  logic [7:0]  mem_addr_a;
  logic [7:0]  mem_addr_b;
  logic [23:0] mem_data_a;
  logic [23:0] mem_data_b;
  logic [2:0]  alu_op;
  logic [23:0] alu_a;
  logic [23:0] alu_b;
  logic [23:0] alu_c;
  logic        alu_z;
  logic        busy;
  logic        done;
  logic [23:0] result;
  logic        result_zero;

  logic [23:0] mem_a [0:255];
  logic [23:0] mem_b [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  // Per-run observations.
  int          lat;
  int          rd_cnt;
  int          busy_cyc;
  logic [2:0]  op_tr [0:31];
  logic [23:0] a_tr  [0:31];
  logic [7:0]  addr_q [$];

  dot_product_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .base_a     (base_a),
    .base_b     (base_b),
    .mem_rd_en  (mem_rd_en),
    .mem_addr_a (mem_addr_a),
    .mem_addr_b (mem_addr_b),
    .mem_data_a (mem_data_a),
    .mem_data_b (mem_data_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .result_zero(result_zero)
  );

  always #5 clk = ~clk;

  // Operand RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_data_a <= mem_a[mem_addr_a];
      mem_data_b <= mem_b[mem_addr_b];
    end
  end

  // Combinational ALU.
  always_comb begin
    alu_c = '0;
    case (alu_op)
      3'd0: alu_c = alu_a + alu_b;
      3'd1: alu_c = alu_a * alu_b;
      3'd2: alu_c = alu_a - alu_b;
      3'd3: alu_c = alu_a >> 8;
      3'd4: alu_c = alu_a << 8;
      default: alu_c = '0;
    endcase
    alu_z = (alu_c == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation in the current cycle (T) and runs until done.
  // With pulses set, start is re-asserted at T+2 and T+4.
  task automatic run(input logic [7:0] n, input logic [7:0] ba, input logic [7:0] bb,
                     input bit pulses);
    bit found;
    found    = 1'b0;
    lat      = 0;
    rd_cnt   = 0;
    busy_cyc = 0;
    addr_q.delete();
    for (int k = 0; k < 32; k++) begin
      op_tr[k] = 'x;
      a_tr[k]  = 'x;
    end
    start  = 1'b1;
    len    = n;
    base_a = ba;
    base_b = bb;
    for (int c = 1; c <= 2000 && !found; c++) begin
      step();
      start = pulses && (c == 2 || c == 4);
      if (c < 32) begin
        op_tr[c] = alu_op;
        a_tr[c]  = alu_a;
      end
      if (mem_rd_en) begin
        rd_cnt++;
        addr_q.push_back(mem_addr_a);
      end
      if (busy) busy_cyc++;
      if (done) begin
        lat   = c;
        found = 1'b1;
      end
    end
    start = 1'b0;
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int d1;
    int d2;
    bit saw_done;
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    mem_a[8'h10] = 24'h000200; mem_b[8'h20] = 24'h000300;
    mem_a[8'h30] = 24'h000100; mem_b[8'h40] = 24'h000400;
    mem_a[8'h31] = 24'h000200; mem_b[8'h41] = 24'h000100;
    mem_a[8'h32] = 24'h000080; mem_b[8'h42] = 24'h000200;
    mem_a[8'h50] = 24'h001000; mem_b[8'h60] = 24'h001000;
    mem_a[8'hFF] = 24'h000100; mem_b[8'h70] = 24'h000200;
    mem_a[8'h00] = 24'h000300; mem_b[8'h71] = 24'h000100;

    rst_n  = 1'b0;
    start  = 1'b0;
    len    = '0;
    base_a = '0;
    base_b = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_result", result, 0);
    check("rst_result_zero", result_zero, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_addr_a", mem_addr_a, 0);
    check("rst_addr_b", mem_addr_b, 0);
    #11 rst_n = 1'b1;
    step();

    // 2.0 * 3.0 = 6.0
    run(8'd1, 8'h10, 8'h20, 1'b0);
    check("t1_latency", lat, 6);
    check("t1_op_mul", op_tr[3], 1);
    check("t1_op_sftr", op_tr[4], 3);
    check("t1_op_add", op_tr[5], 0);
    check("t1_mul_a", a_tr[3], 24'h000200);
    check("t1_prod", a_tr[4], 24'h060000);
    check("t1_busy_cycles", busy_cyc, 6);
    step();
    check("t1_result", result, 24'h000600);
    check("t1_result_zero", result_zero, 0);
    check("t1_busy_after", busy, 0);

    // 4.0 + 2.0 + 1.0 = 7.0 over three elements
    run(8'd3, 8'h30, 8'h40, 1'b0);
    check("t2_latency", lat, 16);
    check("t2_reads", rd_cnt, 3);
    check("t2_addr0", addr_q.size() > 0 ? addr_q[0] : 8'hxx, 8'h30);
    check("t2_addr1", addr_q.size() > 1 ? addr_q[1] : 8'hxx, 8'h31);
    check("t2_addr2", addr_q.size() > 2 ? addr_q[2] : 8'hxx, 8'h32);
    step();
    check("t2_result", result, 24'h000700);
    check("t2_result_zero", result_zero, 0);

    // Empty vector
    run(8'd0, 8'h10, 8'h20, 1'b0);
    check("t3_latency", lat, 1);
    check("t3_reads", rd_cnt, 0);
    check("t3_busy_cycles", busy_cyc, 1);
    step();
    check("t3_result", result, 0);
    check("t3_result_zero", result_zero, 1);
    check("t3_busy_after", busy, 0);

    // 0x1000 * 0x1000 = 0x1000000 truncates to zero
    run(8'd1, 8'h50, 8'h60, 1'b0);
    check("t4_latency", lat, 6);
    check("t4_prod", a_tr[4], 0);
    step();
    check("t4_result", result, 0);
    check("t4_result_zero", result_zero, 1);

    // Address wrap 0xFF -> 0x00: 1.0*2.0 + 3.0*1.0 = 5.0
    run(8'd2, 8'hFF, 8'h70, 1'b0);
    check("t5_latency", lat, 11);
    check("t5_addr0", addr_q.size() > 0 ? addr_q[0] : 8'hxx, 8'hFF);
    check("t5_addr1", addr_q.size() > 1 ? addr_q[1] : 8'hxx, 8'h00);
    step();
    check("t5_result", result, 24'h000500);
    check("t5_result_zero", result_zero, 0);

    // Start pulses during a run are ignored
    run(8'd1, 8'h10, 8'h20, 1'b1);
    check("t6_latency", lat, 6);
    step();
    check("t6_result", result, 24'h000600);
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) saw_done = 1'b1;
      step();
    end
    check("t6_no_restart", saw_done, 0);

    // Start held high: back-to-back operations, one IDLE cycle between
    d1 = 0;
    d2 = 0;
    start  = 1'b1;
    len    = 8'd1;
    base_a = 8'h10;
    base_b = 8'h20;
    for (int c = 1; c <= 40 && d2 == 0; c++) begin
      step();
      if (done) begin
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
    end
    start = 1'b0;
    check("t7_first_done", d1, 6);
    check("t7_second_done", d2, 13);
    step();
    step();
    check("t7_result", result, 24'h000600);

    // Asynchronous reset at T+3 of a three-element run
    start  = 1'b1;
    len    = 8'd3;
    base_a = 8'h30;
    base_b = 8'h40;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t8_busy", busy, 0);
    check("t8_alu_op", alu_op, 0);
    check("t8_alu_a", alu_a, 0);
    check("t8_result", result, 0);
    check("t8_result_zero", result_zero, 0);
    check("t8_rd_en", mem_rd_en, 0);
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    check("t8_no_done", saw_done, 0);
    run(8'd3, 8'h30, 8'h40, 1'b0);
    check("t8_rerun_latency", lat, 16);
    step();
    check("t8_rerun_result", result, 24'h000700);

    // Maximum length: 255 products of 1.0 * 1.0
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 24'h000100;
      mem_b[k] = 24'h000100;
    end
    run(8'd255, 8'h00, 8'h00, 1'b0);
    check("t9_latency", lat, 1276);
    check("t9_reads", rd_cnt, 255);
    step();
    check("t9_result", result, 24'h00FF00);
    check("t9_result_zero", result_zero, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
